omega_calc_stream: RTL and testbench



---
 rtl/omega_calc_pkg.sv | 54 +++++
 rtl/msb_index.sv | 23 ++
 rtl/omega_calc_stream.sv | 162 ++++++++++++++++
 tb/tb_omega_calc_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omega_calc_pkg.sv
// rtl/omega_calc_pkg.sv - shared types, width helpers and arithmetic helpers for omega_calc_stream
//
// Purpose: FSM state encoding, derived-width helpers and the abs/saturate
// helpers used by the normalisation datapath.
// Ports: none (package).
package omega_calc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    NORM  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Difference of two IN_W channels needs one extra bit.
  function automatic int calc_d_w(input int in_w);
    return in_w + 1;
  endfunction

  // Accumulating 2^avg_log2 differences grows by avg_log2 bits.
  function automatic int calc_acc_w(input int in_w, input int avg_log2);
    return calc_d_w(in_w) + avg_log2;
  endfunction

  // Sum of three magnitudes, each below 2^(acc_w-1), fits in acc_w+2 bits.
  function automatic int calc_sum_w(input int in_w, input int avg_log2);
    return calc_acc_w(in_w, avg_log2) + 2;
  endfunction

  // Magnitude of a sign-extended value; callers narrow the result with a cast.
  function automatic logic [63:0] abs_val(input logic signed [63:0] v);
    return (v < 0) ? 64'(-v) : 64'(v);
  endfunction

  // Clamp to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // True when sat_val would change the value.
  function automatic logic sat_hit(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/msb_index.sv
// rtl/msb_index.sv - combinational priority encoder returning the highest set bit index
//
// Purpose: finds the position of the most significant 1 in value; 0 when value is 0.
// Ports:
//   value  in   WIDTH   vector to encode
//   index  out  IDX_W   index of the highest set bit
module msb_index #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] index
);

  // Ascending scan: the last set bit seen wins, i.e. the most significant one.
  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/omega_calc_stream.sv
// rtl/omega_calc_stream.sv - handshaked, optionally averaging omega psi/theta calculator
//
// Purpose: forms X/Y/Z channel differences, accumulates 2^AVG_LOG2 samples,
// normalises by the MSB of the L1 magnitude and presents saturated
// fixed-point omega_psi / omega_theta over a valid/ready pair.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      sample handshake
//   b_plus_* / b_min_*       signed IN_W channel inputs
//   out_valid / out_ready    result handshake
//   omega_psi, omega_theta   signed OUT_W results
//   out_zero                 L1 sum was zero, results forced to 0
//   out_sat                  at least one result was clamped
module omega_calc_stream #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 16,
  parameter int FRAC     = 8,
  parameter int AVG_LOG2 = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  b_plus_x,
  input  logic signed [IN_W-1:0]  b_min_x,
  input  logic signed [IN_W-1:0]  b_plus_y,
  input  logic signed [IN_W-1:0]  b_min_y,
  input  logic signed [IN_W-1:0]  b_plus_z,
  input  logic signed [IN_W-1:0]  b_min_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] omega_psi,
  output logic signed [OUT_W-1:0] omega_theta,
  output logic                    out_zero,
  output logic                    out_sat
);

  import omega_calc_pkg::*;

  localparam int D_W   = calc_d_w(IN_W);
  localparam int ACC_W = calc_acc_w(IN_W, AVG_LOG2);
  localparam int SUM_W = calc_sum_w(IN_W, AVG_LOG2);
  localparam int IW    = ACC_W + FRAC + 2;
  localparam int SH_W  = $clog2(SUM_W);
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int BATCH = 1 << AVG_LOG2;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] ax;
  logic signed [ACC_W-1:0] ay;
  logic signed [ACC_W-1:0] az;
  logic signed [D_W-1:0]   dx;
  logic signed [D_W-1:0]   dy;
  logic signed [D_W-1:0]   dz;
  logic                    accept;
  logic                    last;

  logic [SUM_W-1:0]        sum;
  logic [SH_W-1:0]         sh;
  logic signed [IW-1:0]    psi_full;
  logic signed [IW-1:0]    theta_full;

  // Differences at D_W cannot overflow.
  assign dx = D_W'(b_plus_x) - D_W'(b_min_x);
  assign dy = D_W'(b_plus_y) - D_W'(b_min_y);
  assign dz = D_W'(b_plus_z) - D_W'(b_min_z);

  assign accept = in_valid && in_ready;
  // With AVG_LOG2=0 cnt is a constant 0, so every sample is the last one.
  assign last   = (cnt == CNT_W'(BATCH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ACCUM:   if (accept && last) state_n = NORM;
      NORM:    state_n = HOLD;
      HOLD:    if (out_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulators: the first sample of a batch (cnt==0) loads instead of adding,
  // so no explicit clear is needed between batches.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ax  <= '0;
      ay  <= '0;
      az  <= '0;
    end else if (accept) begin
      if (cnt == '0) begin
        ax <= ACC_W'(dx);
        ay <= ACC_W'(dy);
        az <= ACC_W'(dz);
      end else begin
        ax <= ax + ACC_W'(dx);
        ay <= ay + ACC_W'(dy);
        az <= az + ACC_W'(dz);
      end
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // L1 magnitude of the accumulated vector
  assign sum = SUM_W'(abs_val(64'(ax))) + SUM_W'(abs_val(64'(ay))) + SUM_W'(abs_val(64'(az)));

  msb_index #(
    .WIDTH (SUM_W)
  ) u_msb_index (
    .value (sum),
    .index (sh)
  );

  // Arithmetic right shift floors toward -inf. Theta is negated before the
  // shift; IW has room for -(-2^(ACC_W-1)).
  assign psi_full   = (IW'(ay) <<< FRAC) >>> sh;
  assign theta_full = ((-IW'(az)) <<< FRAC) >>> sh;

  // Result registers, loaded in the single NORM cycle and held through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      omega_psi   <= '0;
      omega_theta <= '0;
      out_zero    <= 1'b0;
      out_sat     <= 1'b0;
    end else if (state == NORM) begin
      if (sum == '0) begin
        omega_psi   <= '0;
        omega_theta <= '0;
        out_zero    <= 1'b1;
        out_sat     <= 1'b0;
      end else begin
        omega_psi   <= OUT_W'(sat_val(64'(psi_full), OUT_W));
        omega_theta <= OUT_W'(sat_val(64'(theta_full), OUT_W));
        out_zero    <= 1'b0;
        out_sat     <= sat_hit(64'(psi_full), OUT_W) || sat_hit(64'(theta_full), OUT_W);
      end
    end
  end

endmodule

// File: tb/tb_omega_calc_stream.sv
// tb/tb_omega_calc_stream.sv - self-checking bench for omega_calc_stream
module tb_omega_calc_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [7:0] px, mx, py, my, pz, mz;

  logic iv0, iv1, iv2;
  logic or0, or1, or2;
  logic ir0, ir1, ir2;
  logic ov0, ov1, ov2;
  logic z0, z1, z2;
  logic s0, s1, s2;
  logic signed [15:0] psi0, th0, psi1, th1;
  logic signed [7:0]  psi2, th2;

  omega_calc_stream dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .b_plus_x(px), .b_min_x(mx), .b_plus_y(py), .b_min_y(my), .b_plus_z(pz), .b_min_z(mz),
    .out_valid(ov0), .out_ready(or0), .omega_psi(psi0), .omega_theta(th0),
    .out_zero(z0), .out_sat(s0)
  );

  omega_calc_stream #(.AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .b_plus_x(px), .b_min_x(mx), .b_plus_y(py), .b_min_y(my), .b_plus_z(pz), .b_min_z(mz),
    .out_valid(ov1), .out_ready(or1), .omega_psi(psi1), .omega_theta(th1),
    .out_zero(z1), .out_sat(s1)
  );

  omega_calc_stream #(.OUT_W(8), .FRAC(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .b_plus_x(px), .b_min_x(mx), .b_plus_y(py), .b_min_y(my), .b_plus_z(pz), .b_min_z(mz),
    .out_valid(ov2), .out_ready(or2), .omega_psi(psi2), .omega_theta(th2),
    .out_zero(z2), .out_sat(s2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     px, mx, py, my, pz, mz;
    longint psi, theta;
    bit     zero, sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_ir(input int k);
    case (k) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction
  function automatic logic get_ov(input int k);
    case (k) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic get_z(input int k);
    case (k) 0: return z0; 1: return z1; default: return z2; endcase
  endfunction
  function automatic logic get_s(input int k);
    case (k) 0: return s0; 1: return s1; default: return s2; endcase
  endfunction
  function automatic longint get_psi(input int k);
    case (k) 0: return longint'(psi0); 1: return longint'(psi1); default: return longint'(psi2); endcase
  endfunction
  function automatic longint get_th(input int k);
    case (k) 0: return longint'(th0); 1: return longint'(th1); default: return longint'(th2); endcase
  endfunction

  task automatic set_iv(input int k, input logic v);
    case (k) 0: iv0 = v; 1: iv1 = v; default: iv2 = v; endcase
  endtask
  task automatic set_or(input int k, input logic v);
    case (k) 0: or0 = v; 1: or1 = v; default: or2 = v; endcase
  endtask

  // Reference model: plain integer arithmetic on the accumulated differences.
  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction
  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction
  function automatic longint clamp(input longint v, input int w, inout bit hit);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction
  task automatic model(input longint ax, ay, az, input int frac, out_w,
                       output longint p, t, output bit z, s);
    longint sum, scale;
    int sh;
    sum = labs(ax) + labs(ay) + labs(az);
    p = 0; t = 0; z = 1'b0; s = 1'b0;
    if (sum == 0) begin
      z = 1'b1;
    end else begin
      sh = 0;
      while ((longint'(1) << (sh + 1)) <= sum) sh++;
      scale = longint'(1) << frac;
      p = clamp(floor_div(ay * scale, longint'(1) << sh), out_w, s);
      t = clamp(floor_div(-az * scale, longint'(1) << sh), out_w, s);
    end
  endtask

  // Offer one sample to dut k; returns at the falling edge after acceptance.
  task automatic put(input int k, input int vpx, vmx, vpy, vmy, vpz, vmz);
    int n;
    @(negedge clk);
    px = 8'(vpx); mx = 8'(vmx); py = 8'(vpy); my = 8'(vmy); pz = 8'(vpz); mz = 8'(vmz);
    set_iv(k, 1'b1);
    n = 0;
    while (!get_ir(k) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("put_in_ready_wait", longint'(get_ir(k)), 1);
    @(negedge clk);
    set_iv(k, 1'b0);
  endtask

  // Called right after put of the last sample: checks the two-cycle latency,
  // the result fields, then releases the result.
  task automatic get(input int k, input string name, input longint ep, et, input bit ez, es);
    check({name, "_lat1"}, longint'(get_ov(k)), 0);
    @(negedge clk);
    check({name, "_lat2"}, longint'(get_ov(k)), 1);
    check({name, "_psi"}, get_psi(k), ep);
    check({name, "_theta"}, get_th(k), et);
    check({name, "_zero"}, longint'(get_z(k)), longint'(ez));
    check({name, "_sat"}, longint'(get_s(k)), longint'(es));
    set_or(k, 1'b1);
    @(negedge clk);
    set_or(k, 1'b0);
    check({name, "_drop"}, longint'(get_ov(k)), 0);
  endtask

  vec_t vecs0[7];
  vec_t vecs2[4];

  initial begin
    longint ep, et, ax, ay, az;
    bit ez, es;
    int v[6];

    vecs0[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs0[1] = '{0, 0, 40, 0, 0, 0, 320, 0, 0, 0};
    vecs0[2] = '{20, 0, 0, 0, 0, 100, 0, 400, 0, 0};
    vecs0[3] = '{0, 0, 0, 3, 0, 0, -384, 0, 0, 0};
    vecs0[4] = '{0, 0, 127, -128, 0, 0, 510, 0, 0, 0};
    vecs0[5] = '{0, 0, 0, 0, -128, 127, 0, 510, 0, 0};
    vecs0[6] = '{0, 0, -5, 0, 0, 0, -320, 0, 0, 0};

    vecs2[0] = '{0, 0, 40, 0, 0, 0, 127, 0, 0, 1};
    vecs2[1] = '{0, 0, 0, 40, 0, 0, -128, 0, 0, 1};
    vecs2[2] = '{0, 0, 0, 0, 40, 0, 0, -128, 0, 1};
    vecs2[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    rst = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
    px = '0; mx = '0; py = '0; my = '0; pz = '0; mz = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", longint'(ir0), 1);
    check("rst_out_valid", longint'(ov0), 0);
    check("rst_psi", longint'(psi0), 0);
    check("rst_theta", longint'(th0), 0);
    check("rst_zero", longint'(z0), 0);
    check("rst_sat", longint'(s0), 0);

    // Directed vectors, default parameters
    for (int i = 0; i < 7; i++) begin
      put(0, vecs0[i].px, vecs0[i].mx, vecs0[i].py, vecs0[i].my, vecs0[i].pz, vecs0[i].mz);
      get(0, $sformatf("vec0_%0d", i), vecs0[i].psi, vecs0[i].theta, vecs0[i].zero, vecs0[i].sat);
    end

    // Directed vectors, OUT_W=8 FRAC=8 (saturating)
    for (int i = 0; i < 4; i++) begin
      put(2, vecs2[i].px, vecs2[i].mx, vecs2[i].py, vecs2[i].my, vecs2[i].pz, vecs2[i].mz);
      get(2, $sformatf("vec2_%0d", i), vecs2[i].psi, vecs2[i].theta, vecs2[i].zero, vecs2[i].sat);
    end

    // Backpressure: result frozen, new data ignored while held
    put(0, 0, 0, 40, 0, 0, 0);
    @(negedge clk);
    check("bp_first_psi", longint'(psi0), 320);
    py = 8'sd100;
    iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(ir0), 0);
      check("bp_out_valid", longint'(ov0), 1);
      check("bp_psi_frozen", longint'(psi0), 320);
    end
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    check("bp_release_ready", longint'(ir0), 1);
    @(negedge clk);
    iv0 = 1'b0;
    check("bp_norm_valid", longint'(ov0), 0);
    @(negedge clk);
    check("bp_next_valid", longint'(ov0), 1);
    check("bp_next_psi", longint'(psi0), 400);
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_no_extra", longint'(ov0), 0);

    // Averaging: four samples form one result
    put(1, 0, 0, 10, 0, 0, 0);
    put(1, 0, 0, 10, 0, 0, 0);
    put(1, 0, 0, 10, 0, 0, 0);
    check("avg_partial_valid", longint'(ov1), 0);
    put(1, 0, 0, 10, 0, 0, 0);
    get(1, "avg4", 320, 0, 0, 0);

    // Reset mid-batch discards the partial accumulation
    put(1, 0, 0, 50, 0, 0, 0);
    put(1, 0, 0, 50, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("avg_rst_ready", longint'(ir1), 1);
    check("avg_rst_valid", longint'(ov1), 0);
    for (int i = 0; i < 3; i++) put(1, 0, 0, 10, 0, 0, 0);
    check("avg_rst_partial", longint'(ov1), 0);
    put(1, 0, 0, 10, 0, 0, 0);
    get(1, "avg_rst", 320, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("avg_rst_single", longint'(ov1), 0);

    // Random single samples against the model
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 6; j++) v[j] = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 7) == 0) for (int j = 0; j < 6; j++) v[j] = 0;
      model(longint'(v[0] - v[1]), longint'(v[2] - v[3]), longint'(v[4] - v[5]), 8, 16, ep, et, ez, es);
      put(0, v[0], v[1], v[2], v[3], v[4], v[5]);
      get(0, $sformatf("rnd0_%0d", i), ep, et, ez, es);
    end

    // Random batches of four on the averaging instance
    for (int b = 0; b < 8; b++) begin
      ax = 0; ay = 0; az = 0;
      for (int s = 0; s < 4; s++) begin
        for (int j = 0; j < 6; j++) v[j] = int'($urandom_range(0, 255)) - 128;
        ax += v[0] - v[1];
        ay += v[2] - v[3];
        az += v[4] - v[5];
        put(1, v[0], v[1], v[2], v[3], v[4], v[5]);
      end
      model(ax, ay, az, 8, 16, ep, et, ez, es);
      get(1, $sformatf("rnd1_%0d", b), ep, et, ez, es);
    end

    // Random samples on the saturating instance
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 6; j++) v[j] = int'($urandom_range(0, 255)) - 128;
      model(longint'(v[0] - v[1]), longint'(v[2] - v[3]), longint'(v[4] - v[5]), 8, 8, ep, et, ez, es);
      put(2, v[0], v[1], v[2], v[3], v[4], v[5]);
      get(2, $sformatf("rnd2_%0d", i), ep, et, ez, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
